// File: rtl/led_ctrl_pkg.sv
// Shared encodings, CPU field positions and the read-word packer for the
// LED display controller (led_ctrl).
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        OWN_HB  = 2'd0,
        OWN_SW  = 2'd1,
        OWN_ERR = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam int PAT_W          = 12;
    localparam int SW_EN_BIT      = 16;
    localparam int ERR_CLR_BIT    = 17;
    localparam int RD_SHOWN_LSB   = 0;
    localparam int RD_OWNER_LSB   = 28;
    localparam int RD_ERR_ACT_BIT = 31;

    localparam logic [3:0] ERR_GREEN = 4'b1000;

    // CPU read word: {err_act, 0, owner, 16'b0, shown}
    function automatic logic [31:0] rd_word(input logic             err_act,
                                            input logic [1:0]       owner,
                                            input logic [PAT_W-1:0] shown);
        logic [31:0] w;
        w                           = 32'h0000_0000;
        w[RD_ERR_ACT_BIT]           = err_act;
        w[RD_OWNER_LSB +: 2]        = owner;
        w[RD_SHOWN_LSB +: PAT_W]    = shown;
        return w;
    endfunction

endpackage

// File: rtl/led_ctrl_timer.sv
// Tick-driven reloadable down-counter; `done` pulses on the tick that
// completes a PERIOD-tick interval. An idle (zero) counter starts a fresh interval.
module led_ctrl_timer #(
    parameter int            TW     = 16,
    parameter logic [TW-1:0] PERIOD = TW'(1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    input  logic tick,
    output logic done
);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] base_s;
    logic [TW-1:0] next_s;

    // Next count value and terminal-tick detection
    always_comb begin
        base_s = (cnt_r == '0) ? PERIOD : cnt_r;
        next_s = base_s - TW'(1);
        done   = run & tick & ~load & (next_s == '0);
    end

    // Counter register: reload wins over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= PERIOD;
        end else if (run & tick) begin
            cnt_r <= next_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED display arbiter (ERR > SW > HB) with a two-state LSB write sequencer.
// Optional feature macro: LED_CTRL_BLINK_EN (blinks the red error code).
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int HOLD_TICKS  = 2000,
    parameter int HB_TICKS    = 500,
    parameter int BLINK_TICKS = 125,
    parameter int TW          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        err_req,
    input  logic [7:0]  err_code,
    output logic        lsb_stb,
    output logic        lsb_we,
    output logic [15:0] lsb_data,
    input  logic        lsb_ack
);

    logic [PAT_W-1:0] sw_pat_r;
    logic             sw_en_r;
    logic             err_act_r;
    logic [7:0]       err_code_r;
    logic             hb_r;
    logic [PAT_W-1:0] shadow_r;
    logic [PAT_W-1:0] wr_word_r;
    state_e           state_r;

    state_e           state_nx_s;
    logic [PAT_W-1:0] wr_word_nx_s;
    logic [PAT_W-1:0] shadow_nx_s;
    owner_e           owner_s;
    logic [PAT_W-1:0] desired_s;
    logic             cpu_wr_s;
    logic             err_clr_s;
    logic             hold_done_s;
    logic             hb_done_s;
    logic             blink_off_s;
    logic             unused_data_s;

    assign cpu_wr_s      = stb & we;
    assign err_clr_s     = cpu_wr_s & data_in[ERR_CLR_BIT];
    assign unused_data_s = ^{data_in[31:18], data_in[15:12]};

    led_ctrl_timer #(
        .TW     (TW),
        .PERIOD (TW'(HOLD_TICKS))
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (err_req),
        .run  (err_act_r),
        .tick (tick),
        .done (hold_done_s)
    );

    led_ctrl_timer #(
        .TW     (TW),
        .PERIOD (TW'(HB_TICKS))
    ) u_hb (
        .clk  (clk),
        .rst  (rst),
        .load (1'b0),
        .run  (1'b1),
        .tick (tick),
        .done (hb_done_s)
    );

`ifdef LED_CTRL_BLINK_EN
    logic blink_r;
    logic blink_done_s;

    led_ctrl_timer #(
        .TW     (TW),
        .PERIOD (TW'(BLINK_TICKS))
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .load (err_req),
        .run  (err_act_r),
        .tick (tick),
        .done (blink_done_s)
    );

    // Blink phase: a new error always starts with the code visible
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_r <= 1'b0;
        end else if (err_req) begin
            blink_r <= 1'b0;
        end else if (blink_done_s) begin
            blink_r <= ~blink_r;
        end else begin
            blink_r <= blink_r;
        end
    end

    assign blink_off_s = blink_r;
`else
    localparam int blink_unused = BLINK_TICKS;
    assign blink_off_s = 1'b0;
`endif

    // Software pattern and enable written from the CPU bus
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_pat_r <= {PAT_W{1'b0}};
            sw_en_r  <= 1'b0;
        end else if (cpu_wr_s) begin
            sw_pat_r <= data_in[PAT_W-1:0];
            sw_en_r  <= data_in[SW_EN_BIT];
        end else begin
            sw_pat_r <= sw_pat_r;
            sw_en_r  <= sw_en_r;
        end
    end

    // Error latch: a new request beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_act_r  <= 1'b0;
            err_code_r <= 8'h00;
        end else if (err_req) begin
            err_act_r  <= 1'b1;
            err_code_r <= err_code;
        end else if (err_clr_s | hold_done_s) begin
            err_act_r  <= 1'b0;
            err_code_r <= err_code_r;
        end else begin
            err_act_r  <= err_act_r;
            err_code_r <= err_code_r;
        end
    end

    // Heartbeat bit toggles every HB_TICKS ticks, independent of owner
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_r <= 1'b0;
        end else if (hb_done_s) begin
            hb_r <= ~hb_r;
        end else begin
            hb_r <= hb_r;
        end
    end

    // Fixed-priority arbitration of the display word
    always_comb begin
        owner_s   = OWN_HB;
        desired_s = {4'b0000, hb_r, 7'b000_0000};
        if (err_act_r) begin
            owner_s   = OWN_ERR;
            desired_s = {ERR_GREEN, (blink_off_s ? 8'h00 : err_code_r)};
        end else if (sw_en_r) begin
            owner_s   = OWN_SW;
            desired_s = sw_pat_r;
        end else begin
            owner_s   = OWN_HB;
            desired_s = {4'b0000, hb_r, 7'b000_0000};
        end
    end

    // Sequencer next state: wr_word only loads from IDLE, so it is frozen in WRITE
    always_comb begin
        state_nx_s   = state_r;
        wr_word_nx_s = wr_word_r;
        shadow_nx_s  = shadow_r;
        case (state_r)
            ST_IDLE: begin
                if (desired_s != shadow_r) begin
                    wr_word_nx_s = desired_s;
                    state_nx_s   = ST_WRITE;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (lsb_ack) begin
                    shadow_nx_s = wr_word_r;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s  = ST_WRITE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_word_r <= {PAT_W{1'b0}};
            shadow_r  <= {PAT_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            wr_word_r <= wr_word_nx_s;
            shadow_r  <= shadow_nx_s;
        end
    end

    assign lsb_stb  = (state_r == ST_WRITE);
    assign lsb_we   = lsb_stb;
    assign lsb_data = {4'b0000, wr_word_r};
    assign ack      = stb;
    assign data_out = (stb & ~we) ? rd_word(err_act_r, owner_s, shadow_r) : 32'h0000_0000;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: directed steps plus randomized traffic
// compared against a tick-counting reference model of the display rules.
module tb_led_ctrl;

    localparam int HOLD  = 6;
    localparam int HB    = 4;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst, tick, stb, we, err_req, lsb_ack;
    logic [31:0] data_in, data_out;
    logic [7:0]  err_code;
    logic        ack, lsb_stb, lsb_we;
    logic [15:0] lsb_data;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int stb_age = 0;
    int writes = 0;
    logic [11:0] led_reg = 12'h000;

    // reference model state
    logic       m_sw_en = 1'b0, m_err_act = 1'b0;
    logic [11:0] m_sw_pat = 12'h000;
    logic [7:0] m_code = 8'h00;
    int         m_err_ticks = 0, m_tick_total = 0;

    led_ctrl #(.HOLD_TICKS(HOLD), .HB_TICKS(HB), .BLINK_TICKS(BLINK), .TW(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .stb(stb), .we(we), .data_in(data_in),
        .data_out(data_out), .ack(ack), .err_req(err_req), .err_code(err_code),
        .lsb_stb(lsb_stb), .lsb_we(lsb_we), .lsb_data(lsb_data), .lsb_ack(lsb_ack));

    always #5 clk = ~clk;

    function automatic logic [1:0] m_owner();
        return m_err_act ? 2'd2 : (m_sw_en ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [11:0] m_desired();
        logic off;
        logic hb;
`ifdef LED_CTRL_BLINK_EN
        off = ((m_err_ticks / BLINK) % 2) == 1;
`else
        off = 1'b0;
`endif
        hb = ((m_tick_total / HB) % 2) == 1;
        if (m_err_act) return {4'b1000, (off ? 8'h00 : m_code)};
        if (m_sw_en) return m_sw_pat;
        return {4'b0000, hb, 7'b000_0000};
    endfunction

    function automatic logic ack_now();
        return lsb_stb && (stb_age >= ack_delay);
    endfunction

    // LSB responder and reference model; inputs are stable here for the next posedge
    always @(negedge clk) begin
        lsb_ack <= ack_now();
        stb_age <= (lsb_stb && !ack_now()) ? stb_age + 1 : 0;
        if (rst) begin
            led_reg <= 12'h000;
        end else if (lsb_stb && ack_now()) begin
            led_reg <= lsb_data[11:0];
            writes  <= writes + 1;
        end
        if (rst) begin
            m_sw_en <= 1'b0; m_err_act <= 1'b0; m_sw_pat <= 12'h000; m_code <= 8'h00;
            m_err_ticks <= 0; m_tick_total <= 0;
        end else begin
            if (err_req) begin
                m_err_act <= 1'b1; m_code <= err_code; m_err_ticks <= 0;
            end else if (stb && we && data_in[17]) begin
                m_err_act <= 1'b0;
            end else if (m_err_act && tick) begin
                m_err_ticks <= m_err_ticks + 1;
                if (m_err_ticks + 1 == HOLD) m_err_act <= 1'b0;
            end
            if (stb && we) begin
                m_sw_pat <= data_in[11:0]; m_sw_en <= data_in[16];
            end
            if (tick) m_tick_total <= m_tick_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic cpu_wr(input logic [31:0] d);
        stb = 1'b1; we = 1'b1; data_in = d;
        step();
        stb = 1'b0; we = 1'b0; data_in = 32'h0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1; step(); tick = 1'b0; step(); step();
        end
    endtask

    task automatic wait_stb(input string tag, input int max);
        for (int i = 0; i < max && !lsb_stb; i++) step();
        chk(tag, {31'h0, lsb_stb}, 32'h1);
    endtask

    // CPU read compared with the model's view after settling
    task automatic rd_model(input string tag);
        stb = 1'b1; we = 1'b0; #1;
        chk(tag, data_out, {m_err_act, 1'b0, m_owner(), 16'h0000, m_desired()});
        chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
        stb = 1'b0; #1;
    endtask

    task automatic rd_bit31(input string tag, input logic exp);
        stb = 1'b1; we = 1'b0; #1;
        chk(tag, {31'h0, data_out[31]}, {31'h0, exp});
        stb = 1'b0; #1;
    endtask

    initial begin
        logic [15:0] d;
        logic [11:0] v;
        int w0;
        rst = 1'b1; tick = 1'b0; stb = 1'b0; we = 1'b0; err_req = 1'b0;
        err_code = 8'h00; data_in = 32'h0;
        settle(3);
        rst = 1'b0;

        // reset, idle with no tick
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_lsb_stb", {31'h0, lsb_stb}, 32'h0);
            chk("idle_data_out", data_out, 32'h0);
        end
        rd_model("reset_read");

        // software pattern, exact latency
        w0 = writes;
        cpu_wr(32'h0001_0A5C);
        chk("sw_n1_stb", {31'h0, lsb_stb}, 32'h0);
        step();
        chk("sw_n2_stb", {31'h0, lsb_stb}, 32'h1);
        chk("sw_n2_data", {16'h0, lsb_data}, 32'h0000_0A5C);
        step();
        chk("sw_n3_stb", {31'h0, lsb_stb}, 32'h0);
        chk("sw_writes", writes, w0 + 1);
        stb = 1'b1; we = 1'b0; #1;
        chk("sw_read", data_out, 32'h1000_0A5C);
        stb = 1'b0; #1;

        // error while SW owns, hold boundary
        err_code = 8'h3C; err_req = 1'b1; step(); err_req = 1'b0;
        wait_stb("err_write_timeout", 3);
        chk("err_data", {16'h0, lsb_data}, 32'h0000_083C);
        tick_n(HOLD - 1);
        settle(4);
        chk("hold_led_before", {20'h0, led_reg}, {20'h0, m_desired()});
        rd_bit31("hold_act_before", 1'b1);
        tick_n(1);
        settle(4);
        chk("hold_led_after", {20'h0, led_reg}, 32'h0000_0A5C);
        rd_bit31("hold_act_after", 1'b0);
        rd_model("hold_read");

        // slow acknowledge with a pattern change mid-write
        ack_delay = 5;
        cpu_wr(32'h0001_0123);
        wait_stb("slow_timeout", 3);
        d = lsb_data;
        w0 = writes;
        chk("slow_data", {16'h0, d}, 32'h0000_0123);
        step();
        chk("slow_hold1", {15'h0, lsb_stb, lsb_data}, {15'h0, 1'b1, d});
        cpu_wr(32'h0001_0456);
        chk("slow_hold2", {15'h0, lsb_stb, lsb_data}, {15'h0, 1'b1, d});
        step();
        chk("slow_hold3", {15'h0, lsb_stb, lsb_data}, {15'h0, 1'b1, d});
        step();
        chk("slow_hold4", {15'h0, lsb_stb, lsb_data}, {15'h0, 1'b1, d});
        ack_delay = 0;
        settle(10);
        chk("slow_writes", writes, w0 + 2);
        chk("slow_led", {20'h0, led_reg}, 32'h0000_0456);

        // same-cycle err_req and err_clr
        stb = 1'b1; we = 1'b1; data_in = 32'h0002_0000; err_req = 1'b1; err_code = 8'h55;
        step();
        stb = 1'b0; we = 1'b0; data_in = 32'h0; err_req = 1'b0;
        settle(6);
        rd_bit31("same_cycle_err_act", 1'b1);
        chk("same_cycle_led", {20'h0, led_reg}, 32'h0000_0855);
        cpu_wr(32'h0002_0000);
        settle(6);
        rd_model("cleared_read");

`ifdef LED_CTRL_BLINK_EN
        err_code = 8'hA5; err_req = 1'b1; step(); err_req = 1'b0;
        settle(5);
        chk("blink_on0", {20'h0, led_reg}, 32'h0000_08A5);
        tick_n(BLINK); settle(4);
        chk("blink_off", {20'h0, led_reg}, 32'h0000_0800);
        tick_n(BLINK); settle(4);
        chk("blink_on1", {20'h0, led_reg}, 32'h0000_08A5);
        cpu_wr(32'h0002_0000);
        settle(6);
`endif

        // heartbeat alternation
        v = led_reg;
        for (int i = 0; i < 4; i++) begin
            tick_n(HB);
            settle(4);
            v = v ^ 12'h080;
            chk("hb_alternate", {20'h0, led_reg}, {20'h0, v});
            chk("hb_model", {20'h0, led_reg}, {20'h0, m_desired()});
        end

        // reset during WRITE
        ack_delay = 20;
        cpu_wr(32'h0001_0777);
        wait_stb("rst_wr_timeout", 3);
        w0 = writes;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_wr_stb_drop", {31'h0, lsb_stb}, 32'h0);
        ack_delay = 0;
        settle(6);
        chk("rst_wr_no_write", writes, w0);
        chk("rst_wr_stb_idle", {31'h0, lsb_stb}, 32'h0);
        rd_model("rst_wr_read");

        // randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            ack_delay = $urandom_range(3);
            for (int c = 0; c < 20; c++) begin
                tick     = ($urandom_range(3) == 0);
                err_req  = ($urandom_range(15) == 0);
                err_code = 8'($urandom);
                stb      = ($urandom_range(4) == 0);
                we       = 1'($urandom_range(1));
                data_in  = $urandom & 32'h0003_0FFF;
                step();
                tick = 1'b0; err_req = 1'b0; stb = 1'b0; we = 1'b0; data_in = 32'h0;
            end
            ack_delay = 0;
            settle(12);
            chk("rand_led", {20'h0, led_reg}, {20'h0, m_desired()});
            chk("rand_stb_idle", {31'h0, lsb_stb}, 32'h0);
            rd_model("rand_read");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
